// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio sample recorder: sample width, default
// sample-RAM address width and the recorder state encoding.
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

endpackage

// File: rtl/audio_sample_recorder_sample_ram.sv
// ---------------------------------------------------------------------------
// sample_ram
// Single-port 2**ADDR_W x DATA_W block RAM with a 1-cycle synchronous read.
// Ports:
//   clock_27mhz  in   system clock
//   we           in   write enable
//   addr         in   ADDR_W  word address (read and write)
//   din          in   DATA_W  write data
//   dout         out  DATA_W  registered read data for the previous cycle's addr
// ---------------------------------------------------------------------------
module sample_ram
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = SAMPLE_W
) (
    input  logic              clock_27mhz,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clock_27mhz) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/audio_sample_recorder.sv
// ---------------------------------------------------------------------------
// audio_sample_recorder
// Record/playback sample store in front of the AC97 interface. In IDLE and
// RECORD the mic sample is passed through on each ready strobe; RECORD also
// stores it in the sample RAM. PLAY returns the stored clip, one sample per
// strobe, then silence (or loops, see below).
// Ports:
//   clock_27mhz     in   system clock
//   reset           in   synchronous, active-high
//   ready           in   one-cycle strobe per AC97 frame
//   audio_in_data   in   8   mic sample, valid on ready
//   record          in   level, hold high to record
//   playback        in   level, hold high to play
//   audio_out_data  out  8   sample to the AC97 interface
//   state           out  2   0 IDLE, 1 RECORD, 2 PLAY
//   full            out  recording reached capacity
//   length          out  ADDR_W+1  number of valid recorded samples
// Build option:
//   AUDIO_RECORDER_LOOP_EN  playback loops over the clip instead of one-shot
// ---------------------------------------------------------------------------
module audio_sample_recorder
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clock_27mhz,
    input  logic                reset,
    input  logic                ready,
    input  logic [SAMPLE_W-1:0] audio_in_data,
    input  logic                record,
    input  logic                playback,
    output logic [SAMPLE_W-1:0] audio_out_data,
    output logic [1:0]          state,
    output logic                full,
    output logic [ADDR_W:0]     length
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_ONE = 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     length_q;
    logic                play_done_q;
    logic                rd_pend_q, rd_hit_q;
    logic [SAMPLE_W-1:0] out_q;

    logic                enter_rec, enter_play;
    logic                ram_we, pass_en, rd_req, rd_hit_d;
    logic [ADDR_W-1:0]   ram_addr;
    logic [SAMPLE_W-1:0] ram_dout;
    logic [ADDR_W-1:0]   rd_next;
    logic                rd_last;
    logic                full_w;

    // Capacity reached exactly when the length MSB is set.
    assign full_w  = length_q[ADDR_W];
    assign rd_next = rd_ptr_q + PTR_ONE;
    assign rd_last = (({1'b0, rd_ptr_q} + LEN_ONE) == length_q);

    // State register
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; record wins over playback.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (record) begin
                    state_d = ST_RECORD;
                end else if (playback) begin
                    state_d = ST_PLAY;
                end
            end
            ST_RECORD: begin
                if (!record) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (record) begin
                    state_d = ST_RECORD;
                end else if (!playback) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/control decode; a strobe coinciding with a transition is
    // handled by the current (old) state.
    always_comb begin
        enter_rec  = (state_d == ST_RECORD) && (state_q != ST_RECORD);
        enter_play = (state_d == ST_PLAY) && (state_q != ST_PLAY);
        ram_we     = (state_q == ST_RECORD) && ready && !full_w;
        pass_en    = ready && (state_q != ST_PLAY);
        rd_req     = ready && (state_q == ST_PLAY);
        rd_hit_d   = rd_req && (length_q != '0) && !play_done_q;
        ram_addr   = (state_q == ST_RECORD) ? wr_ptr_q : rd_ptr_q;
    end

    // Datapath. The read pointer advances one cycle after the strobe so the
    // RAM address stays stable while its registered output is consumed.
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            length_q    <= '0;
            play_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
            out_q       <= '0;
        end else begin
            if (enter_rec) begin
                wr_ptr_q <= '0;
                length_q <= '0;
            end else if (ram_we) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                length_q <= length_q + LEN_ONE;
            end

            rd_pend_q <= rd_req;
            rd_hit_q  <= rd_hit_d;

            if (enter_play) begin
                rd_ptr_q    <= '0;
                play_done_q <= 1'b0;
            end else if (rd_pend_q && rd_hit_q) begin
                if (rd_last) begin
`ifdef AUDIO_RECORDER_LOOP_EN
                    rd_ptr_q <= '0;
`else
                    rd_ptr_q    <= rd_next;
                    play_done_q <= 1'b1;
`endif
                end else begin
                    rd_ptr_q <= rd_next;
                end
            end

            if (pass_en) begin
                out_q <= audio_in_data;
            end else if (rd_pend_q) begin
                out_q <= rd_hit_q ? ram_dout : '0;
            end
        end
    end

    sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_sample_ram (
        .clock_27mhz (clock_27mhz),
        .we          (ram_we),
        .addr        (ram_addr),
        .din         (audio_in_data),
        .dout        (ram_dout)
    );

    assign audio_out_data = out_q;
    assign state          = state_q;
    assign full           = full_w;
    assign length         = length_q;

endmodule

// File: tb/tb_audio_sample_recorder.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_recorder
// Directed bench for audio_sample_recorder. Two instances share all inputs:
// dut_a with ADDR_W=16 and dut_b with ADDR_W=3 (8-sample capacity).
// ---------------------------------------------------------------------------
module tb_audio_sample_recorder;

    logic       clock_27mhz;
    logic       reset;
    logic       ready;
    logic [7:0] audio_in_data;
    logic       record;
    logic       playback;

    logic [7:0]  out_a, out_b;
    logic [1:0]  state_a, state_b;
    logic        full_a, full_b;
    logic [16:0] len_a;
    logic [3:0]  len_b;

    int checks   = 0;
    int failures = 0;

    audio_sample_recorder #(.ADDR_W(16)) dut_a (
        .clock_27mhz    (clock_27mhz),
        .reset          (reset),
        .ready          (ready),
        .audio_in_data  (audio_in_data),
        .record         (record),
        .playback       (playback),
        .audio_out_data (out_a),
        .state          (state_a),
        .full           (full_a),
        .length         (len_a)
    );

    audio_sample_recorder #(.ADDR_W(3)) dut_b (
        .clock_27mhz    (clock_27mhz),
        .reset          (reset),
        .ready          (ready),
        .audio_in_data  (audio_in_data),
        .record         (record),
        .playback       (playback),
        .audio_out_data (out_b),
        .state          (state_b),
        .full           (full_b),
        .length         (len_b)
    );

    initial clock_27mhz = 1'b0;
    always #5 clock_27mhz = ~clock_27mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe is driven at a falling edge and returns at the next falling
    // edge, i.e. one rising edge after the strobe was sampled.
    task automatic strobe(input logic [7:0] d);
        audio_in_data = d;
        ready = 1'b1;
        @(negedge clock_27mhz);
        ready = 1'b0;
    endtask

    task automatic gap();
        repeat (6) @(negedge clock_27mhz);
    endtask

    logic [7:0] pt [3];
    logic [7:0] exp7 [7];
    logic [7:0] eb;

    initial begin
        pt = '{8'h11, 8'h22, 8'h33};
`ifdef AUDIO_RECORDER_LOOP_EN
        exp7 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'h02};
`else
        exp7 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00};
`endif
        reset = 1'b1;
        ready = 1'b0;
        audio_in_data = 8'h00;
        record = 1'b0;
        playback = 1'b0;
        repeat (3) @(negedge clock_27mhz);

        // Reset state
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_out", 32'(out_a), 32'h0);
        chk("rst_len", 32'(len_a), 32'd0);
        chk("rst_full", 32'(full_a), 32'd0);
        reset = 1'b0;
        @(negedge clock_27mhz);

        // IDLE pass-through, 1-cycle latency
        for (int i = 0; i < 3; i++) begin
            strobe(pt[i]);
            chk("pass_out", 32'(out_a), 32'(pt[i]));
            chk("pass_state", 32'(state_a), 32'd0);
            gap();
        end

        // Playback with empty clip: silence, stays in PLAY
        playback = 1'b1;
        @(negedge clock_27mhz);
        chk("empty_state", 32'(state_a), 32'd2);
        for (int i = 0; i < 3; i++) begin
            strobe(8'h5A);
            @(negedge clock_27mhz);
            chk("empty_out_a", 32'(out_a), 32'h0);
            chk("empty_out_b", 32'(out_b), 32'h0);
            gap();
        end
        chk("empty_state_hold", 32'(state_a), 32'd2);
        playback = 1'b0;
        @(negedge clock_27mhz);
        chk("empty_exit", 32'(state_a), 32'd0);

        // Record 5 samples
        record = 1'b1;
        @(negedge clock_27mhz);
        chk("rec_state", 32'(state_a), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            strobe(8'(i));
            gap();
        end
        record = 1'b0;
        @(negedge clock_27mhz);
        chk("rec_exit", 32'(state_a), 32'd0);
        chk("rec_len_a", 32'(len_a), 32'd5);
        chk("rec_len_b", 32'(len_b), 32'd5);
        chk("rec_full", 32'(full_a), 32'd0);

        // Play 7 strobes, 2-cycle latency
        playback = 1'b1;
        @(negedge clock_27mhz);
        for (int i = 0; i < 7; i++) begin
            strobe(8'hC3);
            @(negedge clock_27mhz);
            chk("play5_out_a", 32'(out_a), 32'(exp7[i]));
            chk("play5_out_b", 32'(out_b), 32'(exp7[i]));
            gap();
        end
        chk("play5_state", 32'(state_a), 32'd2);
        playback = 1'b0;
        @(negedge clock_27mhz);
        chk("play5_exit", 32'(state_a), 32'd0);

        // Both levels high from IDLE: record wins
        record = 1'b1;
        playback = 1'b1;
        @(negedge clock_27mhz);
        chk("prio_state", 32'(state_a), 32'd1);
        chk("prio_len", 32'(len_a), 32'd0);
        playback = 1'b0;

        // 10 strobes: dut_b fills after the 8th
        for (int i = 0; i < 10; i++) begin
            strobe(8'(8'hA0 + i));
            chk("fill_full_b", 32'(full_b), (i >= 7) ? 32'd1 : 32'd0);
            chk("fill_len_b", 32'(len_b), (i >= 7) ? 32'd8 : 32'(i + 1));
            chk("fill_len_a", 32'(len_a), 32'(i + 1));
            gap();
        end
        chk("fill_full_a", 32'(full_a), 32'd0);
        record = 1'b0;
        @(negedge clock_27mhz);

        // Play back 10 strobes
        playback = 1'b1;
        @(negedge clock_27mhz);
        for (int i = 0; i < 10; i++) begin
            strobe(8'h3C);
            @(negedge clock_27mhz);
            chk("fill_play_a", 32'(out_a), 32'(8'(8'hA0 + i)));
            if (i < 8) begin
                eb = 8'(8'hA0 + i);
            end else begin
`ifdef AUDIO_RECORDER_LOOP_EN
                eb = 8'(8'hA0 + i - 8);
`else
                eb = 8'h00;
`endif
            end
            chk("fill_play_b", 32'(out_b), 32'(eb));
            gap();
        end
        playback = 1'b0;
        @(negedge clock_27mhz);

        // Reset mid-play forces silence and IDLE
        playback = 1'b1;
        @(negedge clock_27mhz);
        strobe(8'h00);
        @(negedge clock_27mhz);
        chk("rp_out_before", 32'(out_a), 32'hA0);
        reset = 1'b1;
        @(negedge clock_27mhz);
        chk("rp_out", 32'(out_a), 32'h0);
        chk("rp_state", 32'(state_a), 32'd0);
        playback = 1'b0;
        reset = 1'b0;
        @(negedge clock_27mhz);

        // Reset mid-record discards the clip
        record = 1'b1;
        @(negedge clock_27mhz);
        strobe(8'h77);
        chk("rr_pass", 32'(out_a), 32'h77);
        gap();
        chk("rr_len_before", 32'(len_a), 32'd1);
        reset = 1'b1;
        @(negedge clock_27mhz);
        chk("rr_len", 32'(len_a), 32'd0);
        chk("rr_state", 32'(state_a), 32'd0);
        chk("rr_out", 32'(out_a), 32'h0);
        chk("rr_full_b", 32'(full_b), 32'd0);
        record = 1'b0;
        reset = 1'b0;
        @(negedge clock_27mhz);
        chk("rr_idle", 32'(state_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
